nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built from one reused 4-bit slice.
// One nibble per clock, LSB first, with valid/ready on both sides.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_a,
   input  logic [4*NIBBLES-1:0]   in_b,
   input  logic                   in_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   out_sum,
   output logic                   out_cout,
   output logic                   out_ovf,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [4:0]    nib_sum;
   logic          last;

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            a_nib = a_q[i*4 +: 4];
            b_nib = b_q[i*4 +: 4];
         end
      end
      nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
      last    = (idx_q == IW'(NIBBLES - 1));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_sub ? ~in_b : in_b;
               carry_d = in_sub;
               idx_d   = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IW'(i)) begin
                  sum_d[i*4 +: 4] = nib_sum[3:0];
               end
            end
            carry_d = nib_sum[4];
            idx_d   = idx_q + IW'(1);
            if (last) begin
               state_d = S_DONE;
               cout_d  = nib_sum[4];
               // b_q already holds ~B when subtracting
               ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                         (nib_sum[3] != a_q[W-1]);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_ADD) || (state_q == S_DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl at NIBBLES = 4, 1 and 8.
// Arithmetic reference model plus directed literal checks.
module tb_nibble_serial_adder_ctrl;

   typedef struct {
      longint unsigned s;
      bit              c;
      bit              v;
      int              acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm,
                      input longint unsigned act,
                      input longint unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input int w,
                                  input longint unsigned a,
                                  input longint unsigned b,
                                  input bit sub,
                                  input int acc);
      exp_t            e;
      longint unsigned m;
      longint          sa, sb, sr, hi;
      m  = (64'd1 << w) - 64'd1;
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      sr = sub ? sa - sb : sa + sb;
      hi = longint'(1) << (w - 1);
      e.v   = (sr >= hi) || (sr < -hi);
      e.c   = sub ? (a >= b) : ((a + b) > m);
      e.s   = (sub ? a - b : a + b) & m;
      e.acc = acc;
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int N = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
      localparam int W = 4 * N;

      logic         rst_n, in_valid, in_ready, in_sub;
      logic         out_valid, out_ready, out_cout, out_ovf, busy;
      logic [W-1:0] in_a, in_b, out_sum;

      exp_t q[$];
      int   cyc = 0;
      int   last_acc = 0;
      bit   seen = 1'b0;
      bit   b2b = 1'b0;
      bit   b2b_seen = 1'b0;
      bit   fin = 1'b0;

      nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_a      (in_a),
         .in_b      (in_b),
         .in_sub    (in_sub),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_sum   (out_sum),
         .out_cout  (out_cout),
         .out_ovf   (out_ovf),
         .busy      (busy)
      );

      always @(posedge clk) begin
         if (rst_n) begin
            if (out_valid && out_ready && q.size() > 0) begin
               q.delete(0);
               seen = 1'b0;
            end
            if (in_valid && in_ready) begin
               q.push_back(model(W, 64'(in_a), 64'(in_b),
                                 in_sub, cyc));
               if (b2b) begin
                  if (b2b_seen) chk("issue_period", cyc - last_acc, N + 2);
                  b2b_seen = 1'b1;
               end
               last_acc = cyc;
            end
         end
         cyc++;
      end

      always @(negedge rst_n) begin
         q.delete();
         seen = 1'b0;
      end

      always @(negedge clk) begin
         if (!rst_n) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", in_ready, 1);
            chk("rst_sum", out_sum, 0);
            chk("rst_cout", out_cout, 0);
            chk("rst_ovf", out_ovf, 0);
         end else begin
            chk("ready_vs_busy", in_ready, !busy);
            if (out_valid) begin
               if (q.size() == 0) begin
                  chk("spurious_valid", out_valid, 0);
               end else begin
                  chk("model_sum", out_sum, q[0].s);
                  chk("model_cout", out_cout, q[0].c);
                  chk("model_ovf", out_ovf, q[0].v);
                  if (!seen) chk("latency", cyc - q[0].acc, N + 1);
                  seen = 1'b1;
               end
            end
         end
      end

      task automatic wait_ready();
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_ready && n < 200);
         chk("ready_timeout", in_ready, 1);
      endtask

      task automatic wait_valid();
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!out_valid && n < 200);
         chk("valid_timeout", out_valid, 1);
      endtask

      task automatic b2b_run();
         int n;
         out_ready = 1'b1;
         b2b_seen  = 1'b0;
         b2b       = 1'b1;
         for (int i = 0; i < 8; i++) begin
            in_a   = W'({$urandom, $urandom});
            in_b   = W'({$urandom, $urandom});
            in_sub = 1'($urandom_range(0, 1));
            if (i == 0) begin
               in_a   = '1;
               in_b   = W'(1);
               in_sub = 1'b0;
            end
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
         end
         in_valid = 1'b0;
         b2b      = 1'b0;
         n = 0;
         while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("drain", q.size(), 0);
      endtask

      if (g == 0) begin : dir
         task automatic op(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic sub,
                           input logic [W-1:0] es,
                           input logic ec,
                           input logic ev);
            in_a     = a;
            in_b     = b;
            in_sub   = sub;
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait_valid();
            chk("lit_sum", out_sum, es);
            chk("lit_cout", out_cout, ec);
            chk("lit_ovf", out_ovf, ev);
            @(posedge clk);
            #1;
         endtask

         initial begin
            int n, fv;
            logic [W-1:0] fs;
            logic fc, fo;
            rst_n = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b1;
            in_a = '0;
            in_b = '0;
            in_sub = 1'b0;
            #2;
            chk("init_ready", in_ready, 1);
            chk("init_valid", out_valid, 0);
            #20;
            @(negedge clk) rst_n = 1'b1;

            in_a = 16'h1234;
            in_b = 16'h0FFF;
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 0; fv = 0; fs = '0; fc = 1'b0; fo = 1'b0;
            do begin
               @(negedge clk);
               n++;
               if (out_valid && fv == 0) begin
                  fv = n; fs = out_sum; fc = out_cout; fo = out_ovf;
               end
            end while (!in_ready && n < 50);
            chk("first_valid", fv, 5);
            chk("ready_gap", n, 6);
            chk("lit_sum0", fs, 16'h2233);
            chk("lit_cout0", fc, 0);
            chk("lit_ovf0", fo, 0);

            op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
            op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
            op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
            op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

            in_a = 16'h1111;
            in_b = 16'h2222;
            in_sub = 1'b0;
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_a = 16'h0F0F;
            in_b = 16'h0101;
            wait_valid();
            repeat (5) begin
               @(negedge clk);
               chk("bp_valid", out_valid, 1);
               chk("bp_ready", in_ready, 0);
               chk("bp_sum", out_sum, 16'h3333);
               chk("bp_cout", out_cout, 0);
               chk("bp_ovf", out_ovf, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("bp_idle_ready", in_ready, 1);
            chk("bp_idle_valid", out_valid, 0);
            chk("bp_hold_sum", out_sum, 16'h3333);
            @(negedge clk);
            chk("bp_accept", busy, 1);
            in_valid = 1'b0;
            wait_valid();
            chk("bp_new_sum", out_sum, 16'h1010);
            @(posedge clk);
            #1;

            in_a = 16'h4444;
            in_b = 16'h1111;
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_valid", out_valid, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_ready", in_ready, 1);
            chk("mid_rst_sum", out_sum, 0);
            @(negedge clk) rst_n = 1'b1;
            repeat (8) begin
               @(negedge clk);
               chk("post_rst_valid", out_valid, 0);
            end
            op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

            b2b_run();
            fin = 1'b1;
         end
      end else begin : rnd
         initial begin
            rst_n = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b1;
            in_a = '0;
            in_b = '0;
            in_sub = 1'b0;
            #22;
            @(negedge clk) rst_n = 1'b1;
            b2b_run();
            fin = 1'b1;
         end
      end
   end

   initial begin
      int n = 0;
      while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      chk("global_timeout", cfg[0].fin && cfg[1].fin && cfg[2].fin, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
